// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: instruction ROM port, redirect/stall controls from the
// pipeline, the IF/ID register outputs and the status/event counters.
interface fetch_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      rom_addr;
  logic [31:0]      rom_inst;
  logic             stall;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             jmp;
  logic [31:0]      jmp_target;
  logic             halt;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic             ex_flush;
  logic [1:0]       state;
  logic             misalign;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] jmp_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // master: the fetch controller
  modport master (
    output rom_addr, id_inst, id_pc4, id_valid, ex_flush, state, misalign,
           br_cnt, jmp_cnt, stall_cnt,
    input  rom_inst, stall, br_taken, br_target, jmp, jmp_target, halt
  );

  // slave: ROM, hazard unit and the rest of the pipeline
  modport slave (
    input  rom_addr, id_inst, id_pc4, id_valid, ex_flush, state, misalign,
           br_cnt, jmp_cnt, stall_cnt,
    output rom_inst, stall, br_taken, br_target, jmp, jmp_target, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, IF/ID register, redirect and
// stall handling, plus saturating event counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | one cycle after reset; PC held, IF/ID not loaded
//   RUN   | one action per cycle: branch > jump > stall > sequential
//   HALT  | PC frozen, IF/ID emptied, inputs ignored until reset
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q,     state_d;
  logic [31:0]      pc_q,        pc_d;
  logic [31:0]      id_inst_q,   id_inst_d;
  logic [31:0]      id_pc4_q,    id_pc4_d;
  logic             id_valid_q,  id_valid_d;
  logic             misalign_q,  misalign_d;
  logic [CNT_W-1:0] br_cnt_q,    br_cnt_d;
  logic [CNT_W-1:0] jmp_cnt_q,   jmp_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_plus4;
  logic        run;

  assign pc_plus4 = pc_q + 32'd4;
  assign run      = (state_q == ST_RUN);

  // Next-state and register updates; redirects win over stalls, and a halt
  // request lets the current cycle's action complete before freezing.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    misalign_d  = misalign_q;
    br_cnt_d    = br_cnt_q;
    jmp_cnt_d   = jmp_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.br_taken) begin
          pc_d       = {bus.br_target[31:2], 2'b00};
          id_inst_d  = 32'h0;
          id_pc4_d   = 32'h0;
          id_valid_d = 1'b0;
          if (bus.br_target[1:0] != 2'b00) misalign_d = 1'b1;
          if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_ONE;
        end else if (bus.jmp) begin
          pc_d       = {bus.jmp_target[31:2], 2'b00};
          id_inst_d  = 32'h0;
          id_pc4_d   = 32'h0;
          id_valid_d = 1'b0;
          if (bus.jmp_target[1:0] != 2'b00) misalign_d = 1'b1;
          if (jmp_cnt_q != CNT_MAX) jmp_cnt_d = jmp_cnt_q + CNT_ONE;
        end else if (bus.stall) begin
          if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
          pc_d       = pc_plus4;
          id_inst_d  = bus.rom_inst;
          id_pc4_d   = pc_plus4;
          id_valid_d = 1'b1;
        end
        if (bus.halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        // id_pc4 keeps its last value; only the instruction is emptied
        id_inst_d  = 32'h0;
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State registers with synchronous reset overriding all inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      id_inst_q   <= 32'h0;
      id_pc4_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      br_cnt_q    <= '0;
      jmp_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      misalign_q  <= misalign_d;
      br_cnt_q    <= br_cnt_d;
      jmp_cnt_q   <= jmp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Only a taken branch squashes the instruction already in ID
  assign bus.ex_flush  = run && bus.br_taken;
  assign bus.rom_addr  = pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.state     = state_q;
  assign bus.misalign  = misalign_q;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.jmp_cnt   = jmp_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl, plus a narrow-counter instance
// for saturation.
module tb_fetch_ctrl;

  logic clk;
  logic rst;
  logic rst2;

  int total;
  int bad;

  fetch_if #(.CNT_W(16)) bus  ();
  fetch_if #(.CNT_W(2))  bus2 ();

  fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // ROM model: word = 0x1000_0000 | word index
  assign bus.rom_inst  = 32'h1000_0000 | {26'd0, bus.rom_addr[7:2]};
  assign bus2.rom_inst = 32'h1000_0000 | {26'd0, bus2.rom_addr[7:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        halt;
    logic        ef;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
    logic [1:0]  st;
    logic        mis;
    logic [15:0] bc;
    logic [15:0] jc;
    logic [15:0] sc;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic r, input logic s, input logic b, input logic [31:0] bt,
    input logic j, input logic [31:0] jt, input logic h, input logic ef,
    input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4,
    input logic v, input logic [1:0] st, input logic mis,
    input logic [15:0] bc, input logic [15:0] jc, input logic [15:0] sc);
    vec_t x;
    x.rst = r;  x.stall = s; x.br = b; x.bt = bt; x.jmp = j; x.jt = jt;
    x.halt = h; x.ef = ef; x.pc = pc; x.inst = inst; x.pc4 = pc4; x.v = v;
    x.st = st; x.mis = mis; x.bc = bc; x.jc = jc; x.sc = sc;
    return x;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; rst2 = 1'b1;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
    bus.jmp = 1'b0; bus.jmp_target = 32'h0; bus.halt = 1'b0;
    bus2.stall = 1'b0; bus2.br_taken = 1'b0; bus2.br_target = 32'h0;
    bus2.jmp = 1'b0; bus2.jmp_target = 32'h0; bus2.halt = 1'b0;

    //            rst s  b  bt            j  jt            h  ef pc            inst          pc4           v  st    mis bc jc sc
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 32'h80,       0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        32'h10000000, 32'h4,        1, 2'd1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8,        32'h10000001, 32'h8,        1, 2'd1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'hC,        32'h10000002, 32'hC,        1, 2'd1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,       32'h10000003, 32'h10,       1, 2'd1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       32'h10000004, 32'h14,       1, 2'd1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       32'h10000004, 32'h14,       1, 2'd1, 0, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       32'h10000004, 32'h14,       1, 2'd1, 0, 0, 0, 2);
    tbl[9]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       32'h10000004, 32'h14,       1, 2'd1, 0, 0, 0, 3);
    tbl[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h18,       32'h10000005, 32'h18,       1, 2'd1, 0, 0, 0, 3);
    tbl[11] = mk(0, 1, 1, 32'h44,       1, 32'h10,       0, 1, 32'h44,       32'h0,        32'h0,        0, 2'd1, 0, 1, 0, 3);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h48,       32'h10000011, 32'h48,       1, 2'd1, 0, 1, 0, 3);
    tbl[13] = mk(0, 1, 0, 32'h0,        1, 32'h10,       0, 0, 32'h10,       32'h0,        32'h0,        0, 2'd1, 0, 1, 1, 3);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,       32'h10000004, 32'h14,       1, 2'd1, 0, 1, 1, 3);
    tbl[15] = mk(0, 0, 0, 32'h0,        1, 32'h14,       0, 0, 32'h14,       32'h0,        32'h0,        0, 2'd1, 0, 1, 2, 3);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h18,       32'h10000005, 32'h18,       1, 2'd1, 0, 1, 2, 3);
    tbl[17] = mk(0, 0, 0, 32'h0,        1, 32'h23,       0, 0, 32'h20,       32'h0,        32'h0,        0, 2'd1, 1, 1, 3, 3);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h24,       32'h10000008, 32'h24,       1, 2'd1, 1, 1, 3, 3);
    tbl[19] = mk(0, 0, 1, 32'h46,       0, 32'h0,        1, 1, 32'h44,       32'h0,        32'h0,        0, 2'd2, 1, 2, 3, 3);
    tbl[20] = mk(0, 1, 1, 32'h80,       1, 32'h10,       1, 0, 32'h44,       32'h0,        32'h0,        0, 2'd2, 1, 2, 3, 3);
    tbl[21] = mk(1, 0, 1, 32'h80,       0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd0, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd1, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h4,        32'h10000000, 32'h4,        1, 2'd2, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h4,        32'h0,        32'h4,        0, 2'd2, 0, 0, 0, 0);
    tbl[25] = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd0, 0, 0, 0, 0);
    tbl[26] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd1, 0, 0, 0, 0);
    tbl[27] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd1, 0, 0, 0, 1);
    tbl[28] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd0, 0, 0, 0, 0);
    tbl[29] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0, 2'd1, 0, 0, 0, 0);
    tbl[30] = mk(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 2'd1, 0, 0, 1, 0);
    tbl[31] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h1000003F, 32'h0,        1, 2'd1, 0, 0, 1, 0);

    // Initial reset so the first table row starts from a known state
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst            = tbl[i].rst;
      bus.stall      = tbl[i].stall;
      bus.br_taken   = tbl[i].br;
      bus.br_target  = tbl[i].bt;
      bus.jmp        = tbl[i].jmp;
      bus.jmp_target = tbl[i].jt;
      bus.halt       = tbl[i].halt;
      #1;
      chk("ex_flush", i, 64'(bus.ex_flush), 64'(tbl[i].ef));
      @(posedge clk);
      #1;
      chk("rom_addr",  i, 64'(bus.rom_addr),  64'(tbl[i].pc));
      chk("id_inst",   i, 64'(bus.id_inst),   64'(tbl[i].inst));
      chk("id_pc4",    i, 64'(bus.id_pc4),    64'(tbl[i].pc4));
      chk("id_valid",  i, 64'(bus.id_valid),  64'(tbl[i].v));
      chk("state",     i, 64'(bus.state),     64'(tbl[i].st));
      chk("misalign",  i, 64'(bus.misalign),  64'(tbl[i].mis));
      chk("br_cnt",    i, 64'(bus.br_cnt),    64'(tbl[i].bc));
      chk("jmp_cnt",   i, 64'(bus.jmp_cnt),   64'(tbl[i].jc));
      chk("stall_cnt", i, 64'(bus.stall_cnt), 64'(tbl[i].sc));
    end

    // Narrow counter: five consecutive stalls saturate at 3
    @(negedge clk);
    rst = 1'b1;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.halt = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    bus2.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("sat_stall_cnt", k, 64'(bus2.stall_cnt), (k < 2) ? 64'(k + 1) : 64'd3);
      chk("sat_rom_addr",  k, 64'(bus2.rom_addr),  64'd0);
    end
    @(negedge clk);
    bus2.stall = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_hold", 5, 64'(bus2.stall_cnt), 64'd3);
    chk("sat_fetch", 5, 64'(bus2.rom_addr), 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of each event counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rom_addr  output  32  byte address to instruction ROM; equals PC register; ROM indexes word by bits [7:2].
REQ-006 rom_inst  input  32  instruction word returned combinationally by ROM for rom_addr.
REQ-007 stall  input  1  load-use stall request from hazard unit.
REQ-008 br_taken  input  1  conditional branch resolved taken in EX this cycle.
REQ-009 br_target  input  32  branch target byte address, valid with br_taken.
REQ-010 jmp  input  1  unconditional jump decoded in ID this cycle.
REQ-011 jmp_target  input  32  jump target byte address, valid with jmp.
REQ-012 halt  input  1  stop fetching.
REQ-013 id_inst  output  32  IF/ID register: instruction.
REQ-014 id_pc4  output  32  IF/ID register: fetch address + 4.
REQ-015 id_valid  output  1  IF/ID register holds a real instruction.
REQ-016 ex_flush  output  1  combinational; squash the instruction currently in ID (bubble into ID/EX).
REQ-017 state  output  2  00 BOOT, 01 RUN, 10 HALT.
REQ-018 misalign  output  1  sticky: a redirect target had bits [1:0] nonzero.
REQ-019 br_cnt, jmp_cnt, stall_cnt  output  CNT_W each  event counters.

Function
REQ-020 BOOT lasts exactly one cycle: PC held, IF/ID not loaded; next state RUN.
REQ-021 In RUN, one action per cycle, priority br_taken > jmp > stall > sequential fetch.
REQ-022 Sequential fetch: PC <= PC+4 (mod 2^32, 0xFFFFFFFC wraps to 0); id_inst <= rom_inst; id_pc4 <= PC+4; id_valid <= 1.
REQ-023 br_taken: PC <= {br_target[31:2],2'b00}; id_inst <= 0, id_pc4 <= 0, id_valid <= 0; ex_flush = 1 that cycle; br_cnt increments.
REQ-024 jmp (br_taken low): PC <= {jmp_target[31:2],2'b00}; IF/ID squashed as REQ-023; ex_flush = 0; jmp_cnt increments.
REQ-025 Penalty: taken branch 2 bubbles, jump 1 bubble; no bubble on not-taken path.
REQ-026 stall (no redirect): PC and IF/ID registers hold; stall_cnt increments.
REQ-027 Redirect with misaligned target: low bits cleared, misalign set to 1 and held until reset.
REQ-028 br_taken with jmp and/or stall same cycle: branch wins; jmp and stall ignored, their counters unchanged.
REQ-029 halt in RUN (any priority level): next state HALT; that cycle's action per REQ-021 still completes.
REQ-030 HALT: PC held; id_inst <= 0, id_valid <= 0 from the next edge onward; ex_flush = 0; all inputs except rst ignored; exit only by reset.
REQ-031 ex_flush is 0 in BOOT and HALT.
REQ-032 Counters saturate at all-ones, never wrap.
REQ-033 Target equal to current PC is legal (self-loop) and treated as a normal redirect.

Reset
REQ-034 rst high at clock edge: PC = RESET_PC, state = BOOT, id_inst = 0, id_pc4 = 0, id_valid = 0, misalign = 0, all counters 0; overrides every other input.
REQ-035 rst mid-stall, mid-redirect or in HALT: same values as REQ-034 on the next edge; no partial update survives.

Verification
REQ-036 Reset, then 5 free cycles -> rom_addr 0,0,4,8,C; id_valid first 1 after the third edge with id_pc4=4.
REQ-037 PC=0x18 and br_taken=1, br_target=0x44 -> next rom_addr=0x44, id_valid=0, ex_flush=1 during request cycle, br_cnt=1.
REQ-038 jmp=1, jmp_target=0x10 with stall=1 -> rom_addr=0x10, IF/ID squashed, jmp_cnt=1, stall_cnt=0.
REQ-039 stall held 3 cycles at PC=0x14 -> rom_addr, id_inst unchanged for 3 cycles, stall_cnt=3, then rom_addr=0x18.
REQ-040 br_taken, br_target=0x46 plus halt -> PC=0x44, misalign=1, state=HALT; later rst=1 -> all REQ-034 values.
REQ-041 CNT_W=2, 5 consecutive stalls -> stall_cnt=3 and stays 3.
